fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the asynchronous_fifo write port among NUM_REQ requesters.
//  Lives entirely in the write-clock domain. Drives the FIFO's wr_en/data_in and obeys fifo_full.
//  Supports bounded bursts: a winner keeps the port for up to MAX_BURST consecutive writes,
//  then priority rotates to the next requester.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..16)
//  DATA_WIDTH 8  width of each requester word; equals FIFO data width
//  MAX_BURST  4  max consecutive writes per grant (1..255); 1 = pure round-robin
// PORTS
//  wrclk     in   1                   write-domain clock (single clock for this block)
//  wrst_n    in   1                   reset, asynchronous, active-low
//  req       in   NUM_REQ             req[k]=1: requester k has a word on req_data
//  req_data  in   NUM_REQ*DATA_WIDTH  word k = req_data[k*DATA_WIDTH +: DATA_WIDTH]
//  gnt       out  NUM_REQ             one-hot/zero; gnt[k]=1: word k is written at this wrclk edge
//  fifo_full in   1                   from FIFO; no write is issued while high
//  wr_en     out  1                   to FIFO; equals |gnt
//  data_in   out  DATA_WIDTH          to FIFO; word of the granted requester, 0 when no grant
//  owner_id  out  $clog2(NUM_REQ)     current burst owner (registered)
//  busy      out  1                   1 while in BURST state
// BEHAVIOUR
//  - Reset (wrst_n=0, async): state=IDLE, rr_ptr=0, owner_id=0, cnt=0; gnt, wr_en, data_in,
//    and busy forced to 0 regardless of req.
//  - gnt, wr_en, and data_in are combinational from req, fifo_full, and registered state (0-cycle latency).
//    A word is consumed at the wrclk edge that ends the cycle where its gnt is high.
//    Requesters hold req and data stable until granted.
//  - Grant selection, in order:
//    (1) fifo_full=1 -> gnt=0.
//    (2) BURST and req[owner] -> gnt=owner.
//    (3) Otherwise, the first set req found scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//    (4) No req -> gnt=0.
//  - State update at wrclk edge. Let w be the granted index.
//    * w==owner while in BURST: cnt<=cnt+1. If cnt+1==MAX_BURST -> IDLE.
//    * w is a new winner (IDLE, or owner's req low): owner<=w, cnt<=1, rr_ptr<=(w+1) mod NUM_REQ.
//      Next state is BURST if MAX_BURST>1, else IDLE.
//    * No grant and fifo_full=1: state, cnt, and owner hold. A burst stalls without losing its slot.
//    * No grant, fifo_full=0, BURST: owner's req is low and no other req -> IDLE.
//  - cnt is $clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST.
//  - rr_ptr wraps NUM_REQ-1 -> 0.
//  - Owner dropping req mid-burst is handed off in the same cycle to the next requester by round-robin (no bubble).
//  - busy = (state==BURST).
//  - Reset asserted mid-burst aborts immediately. The pending word is not written.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined:
//   - Adds output wr_count (NUM_REQ*16): per-requester 16-bit count of granted writes.
//   - Counters saturate at 16'hFFFF and reset to 0.
//   - Adds input stats_clr (1): synchronous clear of all counters; clear wins over an increment in the same cycle.
//  FIFO_ARB_STATS_EN undefined: the ports and counters are absent; arbitration is identical.
// TESTING
//  1 wrst_n=0 with req=4'hF -> gnt=0, wr_en=0. After release, first grant is gnt=4'b0001.
//  2 MAX_BURST=1, req=4'hF, fifo_full=0 for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3.
//    data_in matches each granted word.
//  3 MAX_BURST=4, req=4'b0011 held -> 4 writes from req0, then 4 from req1, then req0.
//    busy=1 throughout.
//  4 Burst owner at cnt=2; fifo_full=1 for 3 cycles -> wr_en=0, owner_id unchanged.
//    After release, exactly 2 more owner writes, then rotation.
//  5 req0 owns burst and drops req after 2 writes while req2=1 -> gnt=4'b0100 in the very next cycle.
//    rr_ptr becomes 3.
//  6 FIFO_ARB_STATS_EN: 10 grants to req2 -> wr_count[2]=10.
//    Preload near max -> holds at 16'hFFFF.
//    stats_clr together with a grant -> counter reads 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ requesters, the arbiter and the FIFO write side.
// Latency: pure wiring, no storage.
// Backpressure: fifo_full travels toward the arbiter, which withholds gnt/wr_en while it is high.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [IDW-1:0]                owner_id;
    logic                          busy;

    // Requester/FIFO side: presents requests and fullness, observes grants.
    modport master (
        output req, req_data, fifo_full,
        input  gnt, wr_en, data_in, owner_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, fifo_full,
        output gnt, wr_en, data_in, owner_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one FIFO write port; optional per-requester write counters under FIFO_ARB_STATS_EN.
// Latency: gnt/wr_en/data_in are combinational (0 cycles); owner/burst state updates at the wrclk edge.
// Backpressure: fifo_full=1 blocks every grant; a stalled burst keeps its owner and count.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                 wrclk,
    input  logic                 wrst_n,
    fifo_wr_arbiter_if.slave     arb
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [NUM_REQ*16-1:0] wr_count
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;

    logic           scan_vld;
    logic [IDW-1:0] scan_idx;
    logic           keep_owner;
    logic           gnt_vld;
    logic [IDW-1:0] win;
    logic [NUM_REQ-1:0] gnt;

    assign keep_owner = (state_q == BURST) && arb.req[owner_q];
    assign cnt_inc    = cnt_q + CW'(1);

    // Round-robin scan: first active request at or after rr_ptr, wrapping.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int             pos;
            logic [IDW-1:0] cand;
            pos = int'(rr_ptr_q) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDW'(pos);
            if (!scan_vld && arb.req[cand]) begin
                scan_vld = 1'b1;
                scan_idx = cand;
            end
        end
    end

    // Winner selection: full blocks all; a live burst owner beats the scan; reset forces no grant.
    always_comb begin
        gnt_vld = 1'b0;
        win     = '0;
        if (wrst_n && !arb.fifo_full) begin
            if (keep_owner) begin
                gnt_vld = 1'b1;
                win     = owner_q;
            end else if (scan_vld) begin
                gnt_vld = 1'b1;
                win     = scan_idx;
            end
        end
    end

    assign gnt          = gnt_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;
    assign arb.gnt      = gnt;
    assign arb.wr_en    = gnt_vld;
    assign arb.data_in  = gnt_vld ? arb.req_data[win*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign arb.owner_id = owner_q;
    assign arb.busy     = (state_q == BURST);

    // Next-state: extend/finish the burst, hand off to a new winner, or drop to IDLE when nobody asks.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            if (keep_owner) begin
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(MAX_BURST)) begin
                    state_d = IDLE;
                end
            end else begin
                owner_d  = win;
                cnt_d    = CW'(1);
                rr_ptr_d = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
                state_d  = (MAX_BURST > 1) ? BURST : IDLE;
            end
        end else if (!arb.fifo_full && (state_q == BURST)) begin
            // Only reachable when the owner and everyone else have gone quiet.
            state_d = IDLE;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_q;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
        // Per-requester saturating write counter; a clear beats a same-cycle increment.
        always_ff @(posedge wrclk or negedge wrst_n) begin
            if (!wrst_n) begin
                stat_q[k] <= '0;
            end else if (stats_clr) begin
                stat_q[k] <= '0;
            end else if (gnt[k] && (stat_q[k] != 16'hFFFF)) begin
                stat_q[k] <= stat_q[k] + 16'd1;
            end
        end
        assign wr_count[k*16 +: 16] = stat_q[k];
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: one burst instance (MAX_BURST=4) and one pure round-robin instance (MAX_BURST=1).
// Latency: outputs sampled at the falling edge of the same cycle the inputs are applied.
// Backpressure: fifo_full is driven from the vector table.
module tb_fifo_wr_arbiter;
    logic        wrclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;

    always #5 wrclk = ~wrclk;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bif ();
    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) rif ();

    assign bif.req       = req;
    assign bif.req_data  = req_data;
    assign bif.fifo_full = fifo_full;
    assign rif.req       = req;
    assign rif.req_data  = req_data;
    assign rif.fifo_full = fifo_full;

`ifdef FIFO_ARB_STATS_EN
    logic        stats_clr;
    logic [63:0] wr_count_b;
    logic [63:0] wr_count_r;
`endif

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .wrclk     (wrclk),
        .wrst_n    (wrst_n),
        .arb       (bif)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .wr_count  (wr_count_b)
`endif
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut_rr (
        .wrclk     (wrclk),
        .wrst_n    (wrst_n),
        .arb       (rif)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .wr_count  (wr_count_r)
`endif
    );

    typedef struct {
        bit         rst;    // pulse reset before applying
        bit         tgt;    // 0: burst instance, 1: round-robin instance
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit tgt, input logic [3:0] r, input logic f,
                       input logic [3:0] g, input logic b, input logic [1:0] o);
        vec_t v;
        v.rst = rst; v.tgt = tgt; v.req = r; v.full = f;
        v.gnt = g; v.busy = b; v.owner = o;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] word_of(input logic [3:0] g);
        case (g)
            4'b0001: return req_data[7:0];
            4'b0010: return req_data[15:8];
            4'b0100: return req_data[23:16];
            default: return req_data[31:24];
        endcase
    endfunction

    // Called at posedge+1; leaves the design freshly reset at posedge+3.
    task automatic do_reset();
        wrst_n = 1'b0;
        #2;
        wrst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] a_gnt;
        logic       a_busy;
        logic [1:0] a_owner;
        logic       a_wren;
        logic [7:0] a_data;
        logic [7:0] exp_w;

        wrst_n    = 1'b0;
        req       = 4'hF;
        fifo_full = 1'b0;
        req_data  = {8'h69, 8'h78, 8'h4B, 8'h5A};
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // Round-robin instance, pure rotation.
        add(0,1,4'hF,0,4'b0001,0,0); add(0,1,4'hF,0,4'b0010,0,0);
        add(0,1,4'hF,0,4'b0100,0,1); add(0,1,4'hF,0,4'b1000,0,2);
        add(0,1,4'hF,0,4'b0001,0,3); add(0,1,4'hF,0,4'b0010,0,0);
        add(0,1,4'hF,0,4'b0100,0,1); add(0,1,4'hF,0,4'b1000,0,2);
        // Burst instance: two requesters alternate in bursts of 4.
        add(1,0,4'h3,0,4'b0001,0,0); add(0,0,4'h3,0,4'b0001,1,0);
        add(0,0,4'h3,0,4'b0001,1,0); add(0,0,4'h3,0,4'b0001,1,0);
        add(0,0,4'h3,0,4'b0010,0,0); add(0,0,4'h3,0,4'b0010,1,1);
        add(0,0,4'h3,0,4'b0010,1,1); add(0,0,4'h3,0,4'b0010,1,1);
        add(0,0,4'h3,0,4'b0001,0,1); add(0,0,4'h3,0,4'b0001,1,0);
        // Stall at cnt=2, then exactly two more owner writes, then rotation.
        add(0,0,4'h3,1,4'b0000,1,0); add(0,0,4'h3,1,4'b0000,1,0);
        add(0,0,4'h3,1,4'b0000,1,0); add(0,0,4'h3,0,4'b0001,1,0);
        add(0,0,4'h3,0,4'b0001,1,0); add(0,0,4'h3,0,4'b0010,0,0);
        // Owner drops mid-burst: same-cycle handoff, then rr_ptr=3 shown by the scan.
        add(1,0,4'h5,0,4'b0001,0,0); add(0,0,4'h5,0,4'b0001,1,0);
        add(0,0,4'h4,0,4'b0100,1,0); add(0,0,4'h4,0,4'b0100,1,2);
        add(0,0,4'h0,0,4'b0000,1,2); add(0,0,4'hB,0,4'b1000,0,2);
        add(0,0,4'h3,0,4'b0001,1,3); add(0,0,4'h0,0,4'b0000,1,0);
        add(0,0,4'h0,0,4'b0000,0,0); add(0,0,4'h2,1,4'b0000,0,0);
        add(0,0,4'h2,0,4'b0010,0,0);

        // Reset state with every request raised.
        #3;
        check("rst_gnt",   {bif.gnt, rif.gnt}, 32'h0);
        check("rst_wr_en", {bif.wr_en, rif.wr_en}, 32'h0);
        check("rst_data",  {bif.data_in, rif.data_in}, 32'h0);
        check("rst_busy",  {bif.busy, rif.busy}, 32'h0);
        check("rst_owner", {bif.owner_id, rif.owner_id}, 32'h0);
        @(posedge wrclk); #1;
        wrst_n = 1'b1;

        foreach (vecs[v]) begin
            if (vecs[v].rst) do_reset();
            req       = vecs[v].req;
            fifo_full = vecs[v].full;
            if (vecs[v].gnt != 4'b0000) sb_q.push_back(word_of(vecs[v].gnt));
            @(negedge wrclk);
            if (vecs[v].tgt) begin
                a_gnt = rif.gnt; a_busy = rif.busy; a_owner = rif.owner_id;
                a_wren = rif.wr_en; a_data = rif.data_in;
            end else begin
                a_gnt = bif.gnt; a_busy = bif.busy; a_owner = bif.owner_id;
                a_wren = bif.wr_en; a_data = bif.data_in;
            end
            check($sformatf("v%0d_gnt", v),   32'(a_gnt),   32'(vecs[v].gnt));
            check($sformatf("v%0d_busy", v),  32'(a_busy),  32'(vecs[v].busy));
            check($sformatf("v%0d_owner", v), 32'(a_owner), 32'(vecs[v].owner));
            check($sformatf("v%0d_wr_en", v), 32'(a_wren),  32'(|vecs[v].gnt));
            if (a_wren) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_sb_nonempty", v), 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_w = sb_q.pop_front();
                    check($sformatf("v%0d_data", v), 32'(a_data), 32'(exp_w));
                end
            end else begin
                check($sformatf("v%0d_data_idle", v), 32'(a_data), 32'h0);
            end
            @(posedge wrclk); #1;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset mid-burst aborts the pending word, then the first grant goes to req0.
        do_reset();
        req       = 4'b0010;
        fifo_full = 1'b0;
        @(posedge wrclk); @(posedge wrclk); #1;
        check("mid_busy_before", 32'(bif.busy), 32'd1);
        check("mid_owner_before", 32'(bif.owner_id), 32'd1);
        req    = 4'b0011;
        wrst_n = 1'b0;
        #1;
        check("mid_rst_gnt",   32'(bif.gnt), 32'h0);
        check("mid_rst_wr_en", 32'(bif.wr_en), 32'h0);
        check("mid_rst_data",  32'(bif.data_in), 32'h0);
        check("mid_rst_busy",  32'(bif.busy), 32'h0);
        check("mid_rst_owner", 32'(bif.owner_id), 32'h0);
        @(posedge wrclk); #1;
        wrst_n = 1'b1;
        @(negedge wrclk);
        check("post_rst_gnt",  32'(bif.gnt), 32'b0001);
        check("post_rst_data", 32'(bif.data_in), 32'h5A);

`ifdef FIFO_ARB_STATS_EN
        @(posedge wrclk); #1;
        do_reset();
        req = 4'b0100;
        repeat (10) @(posedge wrclk);
        #1;
        check("stat_cnt2",  32'(wr_count_b[47:32]), 32'd10);
        check("stat_cnt0",  32'(wr_count_b[15:0]), 32'd0);
        force dut.stat_q = {16'h0, 16'hFFFD, 16'h0, 16'h0};
        #1;
        release dut.stat_q;
        repeat (4) @(posedge wrclk);
        #1;
        check("stat_sat", 32'(wr_count_b[47:32]), 32'hFFFF);
        stats_clr = 1'b1;
        @(posedge wrclk); #1;
        stats_clr = 1'b0;
        check("stat_clr_wins", 32'(wr_count_b[47:32]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
